// File: rtl/otp_ctrl_pkg.sv
// Shared constants for the otp_ctrl EDN front-end: bus widths, client
// indices and the life-cycle multi-bit escalation encoding.
package otp_ctrl_pkg;

  localparam int EdnBusWidth   = 32;
  localparam int EdnDataWidth  = 64;

  localparam int NumEdnClients = 2;
  localparam int EdnLfsrIdx    = 0;  // LFSR timer reseed
  localparam int EdnKeyIdx     = 1;  // scrambling key-derivation nonce

  // Multi-bit life-cycle signal; anything other than Off counts as asserted.
  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  function automatic logic lc_tx_test_true_loose(input lc_tx_t val);
    return val != Off;
  endfunction

endpackage

// File: rtl/otp_ctrl_edn_arb_pack.sv
// EDN arbiter/packer for otp_ctrl: grants one entropy consumer at a time
// (round-robin), collects EdnBeats EDN beats into one wide word and hands it
// to the granted client with a single-cycle ack.
module otp_ctrl_edn_arb_pack #(
  parameter int NumClients   = otp_ctrl_pkg::NumEdnClients,
  parameter int EdnBusWidth  = otp_ctrl_pkg::EdnBusWidth,
  parameter int EdnDataWidth = otp_ctrl_pkg::EdnDataWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumClients-1:0]     client_req_i,
  output logic [NumClients-1:0]     client_ack_o,
  output logic [EdnDataWidth-1:0]   client_data_o,
  output logic                      edn_req_o,
  input  logic                      edn_ack_i,
  input  logic [EdnBusWidth-1:0]    edn_bus_i,
  input  otp_ctrl_pkg::lc_tx_t      escalate_en_i,
  output logic                      fsm_err_o
);
  import otp_ctrl_pkg::*;

  localparam int EdnBeats = EdnDataWidth / EdnBusWidth;
  localparam int CntW     = $clog2(EdnBeats + 1);
  localparam int IdxW     = (NumClients > 1) ? $clog2(NumClients) : 1;

  // Sparse encoding, pairwise Hamming distance 4, so a single upset lands
  // in an undefined code and is caught by the default branch.
  typedef enum logic [5:0] {
    IdleSt    = 6'b000111,
    FetchSt   = 6'b011001,
    DeliverSt = 6'b101010,
    ErrorSt   = 6'b110100
  } state_e;

  state_e                  r_state, w_state_next;
  logic [IdxW-1:0]         r_gnt_idx, r_rr_ptr, w_pick, w_ptr_inc;
  logic [CntW-1:0]         r_beat_cnt;
  logic [EdnDataWidth-1:0] w_word;
  logic                    w_grant, w_beat_en, w_deliver;
  logic                    w_edn_req, w_fsm_err;
  logic [NumClients-1:0]   w_ack;
  logic [EdnDataWidth-1:0] w_data;

  // First requester at or after ptr, searching upwards with wrap-around.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumClients-1:0] req,
                                              input logic [IdxW-1:0]       ptr);
    int c;
    rr_pick = ptr;
    // descending so the smallest offset from ptr is the last one written
    for (int i = NumClients - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NumClients;
      if (req[c]) rr_pick = IdxW'(c);
    end
  endfunction

  assign w_pick    = rr_pick(client_req_i, r_rr_ptr);
  assign w_ptr_inc = (int'(r_gnt_idx) == NumClients - 1) ? '0 : r_gnt_idx + 1'b1;

  // Next-state and output decode; escalation overrides every state.
  always_comb begin
    w_state_next = r_state;
    w_edn_req    = 1'b0;
    w_ack        = '0;
    w_data       = '0;
    w_fsm_err    = 1'b0;
    w_grant      = 1'b0;
    w_beat_en    = 1'b0;
    w_deliver    = 1'b0;
    case (r_state)
      IdleSt: begin
        if (|client_req_i) begin
          w_grant      = 1'b1;
          w_state_next = FetchSt;
        end
      end
      FetchSt: begin
        w_edn_req = 1'b1;
        if (edn_ack_i) begin
          w_beat_en = 1'b1;
          if (r_beat_cnt == CntW'(EdnBeats - 1)) w_state_next = DeliverSt;
        end
      end
      DeliverSt: begin
        w_deliver = 1'b1;
        // a client that gave up while we were fetching does not get the word
        if (client_req_i[r_gnt_idx]) begin
          w_ack[r_gnt_idx] = 1'b1;
          w_data           = w_word;
        end
        w_state_next = IdleSt;
      end
      ErrorSt: begin
        w_fsm_err = 1'b1;
      end
      default: begin
        w_fsm_err    = 1'b1;
        w_state_next = ErrorSt;
      end
    endcase
    if (lc_tx_test_true_loose(escalate_en_i)) begin
      w_state_next = ErrorSt;
      w_fsm_err    = 1'b1;
    end
  end

  // State register plus grant bookkeeping (winner, beat counter, rr pointer).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IdleSt;
      r_gnt_idx  <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_gnt_idx  <= w_pick;
        r_beat_cnt <= '0;
      end else if (w_beat_en) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_deliver) r_rr_ptr <= w_ptr_inc;
    end
  end

  // One holding register per beat slot; beat 0 sits in the LSBs.
  for (genvar gi = 0; gi < EdnBeats; gi++) begin : g_beat
    logic [EdnBusWidth-1:0] r_beat;
    // capture this slot on its EDN ack; wipe once the word has been offered
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                          r_beat <= '0;
      else if (w_deliver)                                   r_beat <= '0;
      else if (w_beat_en && (r_beat_cnt == CntW'(gi)))      r_beat <= edn_bus_i;
    end
    assign w_word[gi*EdnBusWidth +: EdnBusWidth] = r_beat;
  end

  assign client_ack_o  = w_ack;
  assign client_data_o = w_data;
  assign edn_req_o     = w_edn_req;
  assign fsm_err_o     = w_fsm_err;

  // Protocol properties
  a_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(client_ack_o));
  a_edn_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($past(edn_req_o) && !$past(edn_ack_i) && !lc_tx_test_true_loose($past(escalate_en_i)))
      -> edn_req_o);
  a_outputs_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({client_ack_o, client_data_o, edn_req_o, fsm_err_o}));

endmodule

// File: tb/tb_otp_ctrl_edn_arb_pack.sv
// Bench for otp_ctrl_edn_arb_pack: directed scenarios followed by random
// grants, each compared against a small round-robin/packing model.
`timescale 1ns/1ps
module tb_otp_ctrl_edn_arb_pack;
  import otp_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  client_req;
  logic [1:0]  client_ack;
  logic [63:0] client_data;
  logic        edn_req;
  logic        edn_ack;
  logic [31:0] edn_bus;
  lc_tx_t      esc;
  logic        fsm_err;

  int checks   = 0;
  int failures = 0;
  int rr_model = 0;  // client the arbiter should favour next

  always #5 clk = ~clk;

  otp_ctrl_edn_arb_pack dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .client_req_i  (client_req),
    .client_ack_o  (client_ack),
    .client_data_o (client_data),
    .edn_req_o     (edn_req),
    .edn_ack_i     (edn_ack),
    .edn_bus_i     (edn_bus),
    .escalate_en_i (esc),
    .fsm_err_o     (fsm_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    client_req = 2'b00;
    edn_ack    = 1'b0;
    edn_bus    = '0;
    esc        = Off;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rr_model = 0;
  endtask

  // First requesting client at or after the favoured one, going round the ring.
  function automatic int expected_winner(input logic [1:0] mask);
    for (int k = 0; k < 2; k++)
      if (mask[(rr_model + k) % 2]) return (rr_model + k) % 2;
    return -1;
  endfunction

  // One complete grant starting from idle. Beat b is acked d_b cycles after the
  // fetch begins (d=1 means immediately). Returns ack cycle relative to request.
  task automatic run_grant(input string tag, input logic [1:0] mask,
                           input int d0, input int d1, input bit drop,
                           input logic [31:0] b0, input logic [31:0] b1,
                           output int lat);
    int w;
    int d;
    w          = expected_winner(mask);
    client_req = mask;
    edn_ack    = 1'b1;           // stray ack while idle must be ignored
    edn_bus    = $urandom();
    tick();
    lat     = 1;
    edn_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = (b == 0) ? d0 : d1;
      for (int k = 1; k < d; k++) begin
        chk({tag, "_wait_noack"}, 64'(client_ack), 64'd0);
        edn_bus = $urandom();
        tick();
        lat++;
      end
      chk({tag, "_req_held"}, 64'(edn_req), 64'd1);
      chk({tag, "_fetch_noack"}, 64'(client_ack), 64'd0);
      chk({tag, "_fetch_data0"}, client_data, 64'd0);
      edn_ack = 1'b1;
      edn_bus = (b == 0) ? b0 : b1;
      if (drop && b == 0) client_req[w] = 1'b0;
      tick();
      lat++;
      edn_ack = 1'b0;
    end
    if (drop) begin
      chk({tag, "_drop_ack"}, 64'(client_ack), 64'd0);
      chk({tag, "_drop_data"}, client_data, 64'd0);
    end else begin
      chk({tag, "_ack"}, 64'(client_ack), 64'd1 << w);
      chk({tag, "_data"}, client_data, {b1, b0});
    end
    rr_model = (w + 1) % 2;
    tick();
    chk({tag, "_idle_req"}, 64'(edn_req), 64'd0);
    chk({tag, "_idle_ack"}, 64'(client_ack), 64'd0);
  endtask

  initial begin
    int lat;
    logic [1:0] mask;
    int d0, d1;
    bit drop;

    client_req = 2'b00; edn_ack = 1'b0; edn_bus = '0; esc = Off; rst_n = 1'b0;

    // reset state
    do_reset();
    chk("rst_ack", 64'(client_ack), 64'd0);
    chk("rst_data", client_data, 64'd0);
    chk("rst_edn_req", 64'(edn_req), 64'd0);
    chk("rst_fsm_err", 64'(fsm_err), 64'd0);

    // single client 0, back-to-back beats
    run_grant("single", 2'b01, 1, 1, 1'b0, 32'h11111111, 32'h22222222, lat);
    chk("single_latency", 64'(lat), 64'd3);
    $display("txn single lat=%0d", lat);

    // both held from reset: alternating grants
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_grant("both", 2'b11, 1, 1, 1'b0, $urandom(), $urandom(), lat);
      $display("txn both #%0d next_fav=%0d", i, rr_model);
    end

    // slow EDN: 5 cycles per beat
    run_grant("slow", 2'b01, 5, 5, 1'b0, $urandom(), $urandom(), lat);
    chk("slow_latency", 64'(lat), 64'd11);
    $display("txn slow lat=%0d", lat);

    // client 1 gives up mid-fetch, then client 0 gets fresh beats
    run_grant("drop", 2'b10, 2, 1, 1'b1, $urandom(), $urandom(), lat);
    $display("txn drop lat=%0d", lat);
    run_grant("after_drop", 2'b01, 1, 2, 1'b0, $urandom(), $urandom(), lat);
    $display("txn after_drop lat=%0d", lat);

    // random traffic
    for (int i = 0; i < 24; i++) begin
      mask = 2'($urandom_range(1, 3));
      d0   = $urandom_range(1, 4);
      d1   = $urandom_range(1, 4);
      drop = ($urandom_range(0, 5) == 0);
      run_grant("rand", mask, d0, d1, drop, $urandom(), $urandom(), lat);
      chk("rand_latency", 64'(lat), 64'(d0 + d1 + 1));
      $display("txn rand #%0d mask=%b d0=%0d d1=%0d drop=%0d lat=%0d", i, mask, d0, d1, drop, lat);
    end

    // reset after beat 0: outputs clear, next grant has no stale beat
    client_req = 2'b01;
    tick();
    edn_ack = 1'b1; edn_bus = 32'hDEADBEEF;
    tick();
    edn_ack = 1'b0;
    rst_n   = 1'b0;
    #2;
    chk("midrst_ack", 64'(client_ack), 64'd0);
    chk("midrst_data", client_data, 64'd0);
    chk("midrst_edn_req", 64'(edn_req), 64'd0);
    chk("midrst_fsm_err", 64'(fsm_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rr_model = 0;
    run_grant("post_rst", 2'b01, 1, 1, 1'b0, 32'hAAAA5555, 32'h0F0F0F0F, lat);
    $display("txn post_rst lat=%0d", lat);

    // escalation mid-fetch (On, then another non-Off code)
    for (int e = 0; e < 2; e++) begin
      do_reset();
      client_req = 2'b01;
      tick();
      edn_ack = 1'b1; edn_bus = $urandom();
      tick();
      edn_ack = 1'b0;
      esc = (e == 0) ? On : lc_tx_t'(4'h0);
      tick();
      chk("esc_edn_req", 64'(edn_req), 64'd0);
      chk("esc_fsm_err", 64'(fsm_err), 64'd1);
      chk("esc_ack", 64'(client_ack), 64'd0);
      esc = Off;
      client_req = 2'b11;
      edn_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
        edn_bus = $urandom();
        tick();
        chk("esc_hold_ack", 64'(client_ack), 64'd0);
        chk("esc_hold_req", 64'(edn_req), 64'd0);
        chk("esc_hold_err", 64'(fsm_err), 64'd1);
        chk("esc_hold_data", client_data, 64'd0);
      end
      edn_ack = 1'b0;
      $display("txn escalate code=%0d", e);
    end
    do_reset();
    chk("recover_fsm_err", 64'(fsm_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
